// File: rtl/instr_fetch.sv
// Instruction fetch front end: credit-limited memory requests, in-order prefetch FIFO,
// valid/ready presentation of {instr, pc} to decode, and branch redirect with stale-word discard.
module instr_fetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2,
  parameter logic [11:0] RESET_PC   = 12'o4000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [14:0] instr,
  output logic [11:0] pc,
  output logic        flush,
  input  logic        br_taken,
  input  logic [11:0] br_target,
  input  logic        halt,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [11:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [14:0] mem_rdata
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [11:0] pc;
    logic [14:0] instr;
  } fifo_ent_t;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t                       state_q, state_d;
  fifo_ent_t [FIFO_DEPTH-1:0]   fifo_q, fifo_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [OW-1:0]                outst_q, outst_d, discard_q, discard_d;
  logic [11:0]                  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic                         flush_q, flush_d;
  logic                         grant, push, pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Credit covers both in-flight words and buffered words, so a push never overflows.
  assign mem_req = (state_q == RUN) && (outst_q < OW'(MAX_OUTST)) &&
                   ((32'(outst_q) + 32'(cnt_q)) < 32'(FIFO_DEPTH)) && (discard_q == '0);
  assign mem_addr    = fetch_pc_q;
  assign grant       = mem_req && mem_gnt;
  assign instr_valid = (cnt_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign push        = mem_rvalid && (discard_q == '0) && !br_taken;
  assign instr       = fifo_q[rd_ptr_q].instr;
  assign pc          = fifo_q[rd_ptr_q].pc;
  assign flush       = flush_q;

  always_comb begin
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q + OW'(grant) - OW'(mem_rvalid);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    flush_d    = br_taken;
    if (br_taken) begin
      // Everything still in flight after this cycle belongs to the old stream.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      fetch_pc_d = br_target;
      resp_pc_d  = br_target;
      discard_d  = outst_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 12'd1;
      if (mem_rvalid && (discard_q != '0)) discard_d = discard_q - OW'(1);
      if (push) begin
        fifo_d[wr_ptr_q] = {resp_pc_q, mem_rdata};
        wr_ptr_d         = wr_ptr_q + PW'(1);
        resp_pc_d        = resp_pc_q + 12'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= {RESET_PC, 15'd0};
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      flush_q    <= flush_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bench-side memory with in-order random latency, a queue-based
// model of requests and buffered words, per-cycle output comparison, and directed scenarios.
module tb_instr_fetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid, instr_ready, flush, br_taken, halt;
  logic        mem_req, mem_gnt, mem_rvalid;
  logic [14:0] instr, mem_rdata;
  logic [11:0] pc, br_target, mem_addr;

  instr_fetch #(.FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO), .RESET_PC(12'o4000)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .flush(flush), .br_taken(br_taken), .br_target(br_target),
    .halt(halt), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct { logic [11:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [11:0] pc; logic [14:0] instr; } ent_t;

  req_t        mq[$];   // granted, not yet answered (memory side and model outstanding set)
  ent_t        fq[$];   // words decode should see, in order
  logic [11:0] fpc_m;
  bit          started, run_m, flush_m, exp_req, exp_valid;
  int          cyc, lastdue;
  int          errors, checks;

  int          gnt_pct, rdy_pct, lat_lo, lat_hi, br_pct, halt_pct;
  bit          br_now, br_arm, halt_now, pin_on_br;
  logic [11:0] br_tgt;

  bit          fg_watch, fv_watch, last_valid, have_prev, saw_wrap;
  logic [11:0] pin_pc, last_pc, prev_pop_pc;
  int          pin_lat, g_cyc, flush_cnt, pops;

  function automatic logic [14:0] data_of(input logic [11:0] a);
    return {a[2:0], a} ^ 15'h5a3c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    int ns = 0;
    foreach (mq[i]) if (mq[i].stale) ns++;
    exp_req   = run_m && (mq.size() < MAXO) && ((mq.size() + fq.size()) < DEPTH) && (ns == 0);
    exp_valid = fq.size() > 0;
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, fpc_m);
    chk("instr_valid", instr_valid, exp_valid);
    if (exp_valid) begin
      chk("pc", pc, fq[0].pc);
      chk("instr", instr, fq[0].instr);
    end
    chk("flush", flush, flush_m);
    if (flush) flush_cnt++;
    if (fg_watch && mem_req) chk("first_addr", mem_addr, pin_pc);
    if (fv_watch && instr_valid) begin
      fv_watch = 0;
      chk("first_pc", pc, pin_pc);
      if (pin_lat > 0) chk("first_lat", cyc - g_cyc, pin_lat);
    end
    last_valid = instr_valid;
    last_pc    = pc;
  endtask

  task automatic drive();
    mem_rvalid  = (mq.size() > 0) && (mq[0].due <= cyc);
    mem_rdata   = mem_rvalid ? data_of(mq[0].addr) : 15'($urandom);
    mem_gnt     = $urandom_range(99) < gnt_pct;
    instr_ready = $urandom_range(99) < rdy_pct;
    br_taken    = br_now || ($urandom_range(99) < br_pct) ||
                  (br_arm && mem_rvalid && exp_req && mem_gnt);
    br_target   = (br_now || br_arm) ? br_tgt : 12'($urandom);
    if (halt_pct > 0 && $urandom_range(99) < halt_pct) halt_now = !halt_now;
    halt = halt_now;
  endtask

  task automatic update();
    bit   g, ok, pp;
    int   d;
    req_t r;
    g  = exp_req && mem_gnt;
    ok = 0;
    if (mem_rvalid) begin
      r  = mq.pop_front();
      ok = !r.stale && !br_taken;
    end
    if (g) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= lastdue) d = lastdue + 1;
      lastdue = d;
      mq.push_back('{fpc_m, d, 1'b0});
      if (fg_watch) begin
        fg_watch = 0;
        g_cyc    = cyc;
        fv_watch = 1;
      end
    end
    pp = exp_valid && instr_ready;
    if (last_valid && instr_ready && !br_taken) begin
      pops++;
      if (have_prev && prev_pop_pc == 12'o7777 && last_pc == 12'o0000) saw_wrap = 1;
      prev_pop_pc = last_pc;
      have_prev   = 1;
    end
    if (br_taken) begin
      fq.delete();
      foreach (mq[i]) mq[i].stale = 1;
      fpc_m   = br_target;
      flush_m = 1;
      if (br_arm) br_arm = 0;
      if (pin_on_br) begin
        pin_on_br = 0;
        fv_watch  = 1;
        pin_lat   = -1;
        pin_pc    = br_target;
      end
    end else begin
      flush_m = 0;
      if (g) fpc_m = fpc_m + 12'd1;
      if (pp) void'(fq.pop_front());
      if (ok) fq.push_back('{r.addr, data_of(r.addr)});
    end
    if (!started) begin
      started = 1;
      run_m   = 1;
    end else begin
      run_m = !halt;
    end
    cyc++;
  endtask

  task automatic cycle();
    compare();
    drive();
    @(posedge clock);
    update();
    @(negedge clock);
  endtask

  task automatic rst_vals(input string tag);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_pc"}, pc, 12'o4000);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, mem_addr, 12'o4000);
  endtask

  task automatic do_reset();
    reset = 1; mem_gnt = 0; mem_rvalid = 0; instr_ready = 0; br_taken = 0;
    halt = 0; halt_now = 0; mem_rdata = 0; br_target = 0;
    mq.delete(); fq.delete();
    fpc_m = 12'o4000; started = 0; run_m = 0; flush_m = 0; lastdue = 0;
    last_valid = 0; have_prev = 0;
    repeat (2) @(negedge clock);
    rst_vals("rst");
    reset = 0;
  endtask

  task automatic knobs(input int g, input int r, input int lo, input int hi);
    gnt_pct = g; rdy_pct = r; lat_lo = lo; lat_hi = hi;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0;
    br_pct = 0; halt_pct = 0; br_now = 0; br_arm = 0; pin_on_br = 0;
    fv_watch = 0; flush_cnt = 0; pops = 0; saw_wrap = 0;

    // 1: streaming start, first word two cycles after first grant
    knobs(100, 100, 1, 1);
    fg_watch = 1; pin_pc = 12'o4000; pin_lat = 2;
    do_reset();
    repeat (12) cycle();
    chk("t1_first_valid_seen", fv_watch, 0);

    // 2: decode stalls, FIFO fills, then drains exactly FIFO_DEPTH words
    knobs(100, 0, 1, 1);
    repeat (10) cycle();
    chk("t2_req_low", mem_req, 0);
    chk("t2_valid_held", instr_valid, 1);
    knobs(0, 100, 1, 1);
    pops = 0;
    repeat (8) cycle();
    chk("t2_drain_words", pops, DEPTH);

    // 3: redirect with two requests outstanding
    knobs(100, 100, 4, 4);
    for (int i = 0; i < 20 && mq.size() != 2; i++) cycle();
    chk("t3_outst_setup", mq.size(), 2);
    br_tgt = 12'o5000; br_now = 1; pin_on_br = 1; flush_cnt = 0;
    cycle();
    br_now = 0;
    repeat (15) cycle();
    chk("t3_flush_pulses", flush_cnt, 1);
    chk("t3_pc_seen", fv_watch, 0);

    // 4: redirect coinciding with a response and a grant
    knobs(100, 100, 1, 1);
    repeat (6) cycle();
    br_arm = 1; br_tgt = 12'o6000; pin_on_br = 1;
    for (int i = 0; i < 20 && br_arm; i++) cycle();
    chk("t4_fired", br_arm, 0);
    repeat (10) cycle();
    chk("t4_pc_seen", fv_watch, 0);

    // 5: address wrap, then halt and resume
    br_tgt = 12'o7776; br_now = 1;
    cycle();
    br_now = 0; have_prev = 0; saw_wrap = 0;
    repeat (12) cycle();
    chk("t5_wrap", saw_wrap, 1);
    knobs(100, 100, 3, 3);
    halt_now = 1;
    repeat (10) cycle();
    chk("t5_halt_req", mem_req, 0);
    chk("t5_halt_drained", instr_valid, 0);
    halt_now = 0; pops = 0;
    repeat (10) cycle();
    chk("t5_resume", pops > 0, 1);

    // random traffic
    knobs(70, 70, 1, 5);
    br_pct = 3; halt_pct = 5;
    repeat (3000) cycle();
    br_pct = 0; halt_pct = 0; halt_now = 0;

    // 6: asynchronous reset with buffered words and full credit outstanding
    knobs(0, 100, 1, 1);
    repeat (15) cycle();
    knobs(100, 0, 6, 6);
    for (int i = 0; i < 40 && !(mq.size() == 2 && fq.size() == 2); i++) cycle();
    chk("t6_setup", (mq.size() == 2) && (fq.size() == 2), 1);
    compare();
    drive();
    #2 reset = 1;
    #1 rst_vals("async");
    knobs(100, 100, 1, 1);
    fg_watch = 1; pin_pc = 12'o4000; pin_lat = 2;
    do_reset();
    repeat (10) cycle();
    chk("t6_restart_seen", fv_watch, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
